// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode map, ALU function codes, sequencer states and control-word type
// shared by ram_datapath_ctrl and ctrl_word_decode.
package ctrl_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_SUBS = 4'd5;
    localparam logic [3:0] OP_LDUR = 4'd6;
    localparam logic [3:0] OP_STUR = 4'd7;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    typedef enum logic [2:0] {IDLE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, ERR} state_e;
    typedef struct packed {
        logic       w;
        logic       en_b;
        logic       en_alu;
        logic       en_addr;
        logic       k_sel;
        logic       pc_sel;
        logic       c0;
        logic       we;
        logic       oe;
        logic       done;
        logic       err;
        logic [4:0] fs;
    } ctrl_t;
    function automatic state_e first_state(input logic [3:0] op);
        return (op <= OP_SUBS) ? EXEC : (op <= OP_STUR) ? MEM_ADDR : ERR;
    endfunction
    function automatic logic [4:0] alu_fs(input logic [3:0] op);
        return (op == OP_ADD || op == OP_ADDI) ? FS_ADD :
               (op == OP_SUB || op == OP_SUBS) ? FS_SUB :
               (op == OP_ORR) ? FS_ORR : FS_AND;
    endfunction
endpackage

// File: rtl/ctrl_word_decode.sv
// ctrl_word_decode: combinational control word for the state being entered and the
// instruction in flight; every field not used by that state is forced to zero.
module ctrl_word_decode
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  state_e              st_i,
    input  logic [3:0]          op_i,
    input  logic [REG_AW-1:0]   rd_i,
    input  logic [REG_AW-1:0]   rn_i,
    input  logic [REG_AW-1:0]   rm_i,
    input  logic [DATA_W-1:0]   imm_i,
    output ctrl_t               ctrl_o,
    output logic [REG_AW-1:0]   sa_o,
    output logic [REG_AW-1:0]   sb_o,
    output logic [REG_AW-1:0]   da_o,
    output logic [DATA_W-1:0]   k_o
);
    logic exec, mem;
    assign exec = st_i == EXEC;
    assign mem  = st_i inside {MEM_ADDR, MEM_RD, MEM_WR};
    always_comb begin
        ctrl_o.w       = exec || st_i == MEM_RD;
        ctrl_o.en_b    = st_i == MEM_WR;
        ctrl_o.en_alu  = exec;
        ctrl_o.en_addr = mem;
        ctrl_o.k_sel   = mem || (exec && op_i == OP_ADDI);
        ctrl_o.pc_sel  = 1'b0;
        ctrl_o.c0      = exec && (op_i == OP_SUB || op_i == OP_SUBS);
        ctrl_o.we      = st_i == MEM_WR;
        // OE only for loads: a store's address phase must leave the bus free for EN_B
        ctrl_o.oe      = (st_i == MEM_ADDR && op_i == OP_LDUR) || st_i == MEM_RD;
        ctrl_o.done    = exec || st_i == MEM_RD || st_i == MEM_WR;
        ctrl_o.err     = st_i == ERR;
        ctrl_o.fs      = mem ? FS_ADD : exec ? alu_fs(op_i) : 5'd0;
        sa_o           = (exec || mem) ? rn_i : '0;
        sb_o           = exec ? rm_i : (st_i == MEM_WR) ? rd_i : '0;
        da_o           = ctrl_o.w ? rd_i : '0;
        k_o            = ctrl_o.k_sel ? imm_i : '0;
    end
endmodule

// File: rtl/ram_datapath_ctrl.sv
// ram_datapath_ctrl: multi-cycle sequencer driving the RAM datapath control word.
// Optional CTRL_PERF_CNT_EN adds instr_retired / mem_cycles counters.
module ram_datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic [DATA_W-1:0] imm,
    input  logic [3:0]        status,
    output logic              W,
    output logic              EN_B,
    output logic              EN_ALU,
    output logic              EN_ADDR,
    output logic              K_SEL,
    output logic              PC_SEL,
    output logic              C0,
    output logic              WE,
    output logic              OE,
    output logic [REG_AW-1:0] SA,
    output logic [REG_AW-1:0] SB,
    output logic [REG_AW-1:0] DA,
    output logic [4:0]        FS,
    output logic [DATA_W-1:0] K,
    output logic [3:0]        flags,
    output logic              instr_done,
    output logic              instr_err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       instr_retired,
    output logic [31:0]       mem_cycles
`endif
);
    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d, flags_q;
    logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d, sa_q, sa_d, sb_q, sb_d, da_q, da_d;
    logic [DATA_W-1:0] imm_q, imm_d, k_q, k_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              accept;

    assign instr_ready = rst && state_q == IDLE;
    assign accept      = instr_valid && instr_ready;

    // decode sees the incoming fields on the accepting edge so the first state is valid immediately
    always_comb begin
        op_d    = accept ? op  : op_q;
        rd_d    = accept ? rd  : rd_q;
        rn_d    = accept ? rn  : rn_q;
        rm_d    = accept ? rm  : rm_q;
        imm_d   = accept ? imm : imm_q;
        state_d = (state_q == IDLE) ? (accept ? first_state(op) : IDLE) :
                  (state_q == MEM_ADDR) ? (op_q == OP_LDUR ? MEM_RD : MEM_WR) : IDLE;
    end

    ctrl_word_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
        .st_i(state_d), .op_i(op_d), .rd_i(rd_d), .rn_i(rn_d), .rm_i(rm_d), .imm_i(imm_d),
        .ctrl_o(ctrl_d), .sa_o(sa_d), .sb_o(sb_d), .da_o(da_d), .k_o(k_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            da_q    <= '0;
            k_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            da_q    <= da_d;
            k_q     <= k_d;
            flags_q <= (state_q == EXEC && op_q == OP_SUBS) ? status : flags_q;
        end
    end

    assign {W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, WE, OE} =
        {ctrl_q.w, ctrl_q.en_b, ctrl_q.en_alu, ctrl_q.en_addr, ctrl_q.k_sel,
         ctrl_q.pc_sel, ctrl_q.c0, ctrl_q.we, ctrl_q.oe};
    assign instr_done = ctrl_q.done;
    assign instr_err  = ctrl_q.err;
    assign FS         = ctrl_q.fs;
    assign SA         = sa_q;
    assign SB         = sb_q;
    assign DA         = da_q;
    assign K          = k_q;
    assign flags      = flags_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q, mem_cyc_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
            mem_cyc_q <= '0;
        end else begin
            retired_q <= retired_q + {31'd0, ctrl_q.done};
            mem_cyc_q <= mem_cyc_q + {31'd0, state_q inside {MEM_ADDR, MEM_RD, MEM_WR}};
        end
    end
    assign instr_retired = retired_q;
    assign mem_cycles    = mem_cyc_q;
`endif
endmodule

// File: tb/tb_ram_datapath_ctrl.sv
// tb_ram_datapath_ctrl: directed and randomized checks of ram_datapath_ctrl against a
// per-opcode cycle-plan model; define CTRL_PERF_CNT_EN to also check the counters.
module tb_ram_datapath_ctrl;
    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_ready;
    logic [3:0]  op, status, flags;
    logic [4:0]  rd, rn, rm, SA, SB, DA, FS;
    logic [63:0] imm, K;
    logic        W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, WE, OE, instr_done, instr_err;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_retired, mem_cycles;
`endif

    always #5 clk = ~clk;

    ram_datapath_ctrl #(.DATA_W(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .status(status),
        .W(W), .EN_B(EN_B), .EN_ALU(EN_ALU), .EN_ADDR(EN_ADDR), .K_SEL(K_SEL),
        .PC_SEL(PC_SEL), .C0(C0), .WE(WE), .OE(OE), .SA(SA), .SB(SB), .DA(DA),
        .FS(FS), .K(K), .flags(flags), .instr_done(instr_done), .instr_err(instr_err)
`ifdef CTRL_PERF_CNT_EN
        , .instr_retired(instr_retired), .mem_cycles(mem_cycles)
`endif
    );

    // one expected output cycle; upd marks the cycle whose closing edge captures status
    typedef struct packed {
        logic w, en_b, en_alu, en_addr, k_sel, pc_sel, c0, we, oe, done, err, upd;
        logic [4:0] sa, sb, da, fs;
        logic [63:0] k;
    } rec_t;

    rec_t        plan_q[$];
    rec_t        cur, act;
    logic [3:0]  flags_m;
    logic [31:0] ret_m, mem_m;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // the cycles an accepted instruction must produce, in order
    task automatic plan(input logic [3:0] o, input logic [4:0] d, n, m, input logic [63:0] i);
        rec_t a;
        a = '0;
        if (o <= 4'd5) begin
            a.en_alu = 1; a.w = 1; a.done = 1;
            a.sa = n; a.sb = m; a.da = d;
            a.c0 = (o == 1 || o == 5);
            a.fs = (o == 2) ? 5'd0 : (o == 3) ? 5'd4 : (o == 1 || o == 5) ? 5'd10 : 5'd8;
            a.k_sel = (o == 4);
            a.k = (o == 4) ? i : 64'd0;
            a.upd = (o == 5);
            plan_q.push_back(a);
        end else if (o == 4'd6 || o == 4'd7) begin
            a.sa = n; a.k = i; a.k_sel = 1; a.fs = 5'd8; a.en_addr = 1; a.oe = (o == 6);
            plan_q.push_back(a);
            a.done = 1;
            if (o == 6) begin
                a.w = 1; a.da = d;
            end else begin
                a.sb = d; a.en_b = 1; a.we = 1;
            end
            plan_q.push_back(a);
        end else begin
            a.err = 1;
            plan_q.push_back(a);
        end
    endtask

    // advance model across one rising edge, then compare every output at the falling edge
    task automatic cyc();
        if (!rst) begin
            plan_q.delete();
            cur = '0; flags_m = '0; ret_m = '0; mem_m = '0;
        end else begin
            if (cur.upd) flags_m = status;
            if (cur.done) ret_m++;
            if (cur.en_addr) mem_m++;
            if (cur == '0 && instr_valid) plan(op, rd, rn, rm, imm);
            cur = (plan_q.size() != 0) ? plan_q.pop_front() : '0;
        end
        @(posedge clk);
        @(negedge clk);
        act = {W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, WE, OE, instr_done, instr_err,
               cur.upd, SA, SB, DA, FS, K};
        chk("ctrl_word", act, cur);
        chk("flags", flags, flags_m);
        chk("ready", instr_ready, cur == '0 && rst);
        chk("bus_one_driver", (int'(EN_B) + int'(EN_ALU) + int'(OE)) <= 1, 1);
        chk("we_oe_exclusive", WE && OE, 0);
`ifdef CTRL_PERF_CNT_EN
        chk("instr_retired", instr_retired, ret_m);
        chk("mem_cycles", mem_cycles, mem_m);
`endif
    endtask

    task automatic issue(input logic [3:0] o, input logic [4:0] d, n, m, input logic [63:0] i);
        op = o; rd = d; rn = n; rm = m; imm = i; instr_valid = 1;
        cyc();
        instr_valid = 0;
        op = 4'd0; rd = '0; rn = '0; rm = '0; imm = '0;
    endtask

    initial begin
        rst = 0; instr_valid = 1; op = 4'd4; rd = 0; rn = 0; rm = 0; imm = 0; status = 0;
        cur = '0; flags_m = '0; ret_m = '0; mem_m = '0;
        cyc();
        chk("reset_ready", instr_ready, 0);
        chk("reset_w", W, 0);
        cyc();
        rst = 1; instr_valid = 0;
        cyc();
        chk("ready_after_reset", instr_ready, 1);

        issue(4'd4, 5'd3, 5'd1, 5'd0, 64'd5);
        chk("addi_k", K, 64'd5);
        chk("addi_fs", FS, 5'b01000);
        chk("addi_ctl", {K_SEL, EN_ALU, W, instr_done}, 4'b1111);
        chk("addi_da", DA, 5'd3);
        cyc();
        chk("addi_ready_back", instr_ready, 1);

        status = 4'b0001;
        issue(4'd5, 5'd0, 5'd2, 5'd2, 64'd0);
        chk("subs_fs", FS, 5'b01010);
        chk("subs_c0", C0, 1);
        cyc();
        chk("subs_flags", flags, 4'b0001);
        status = 4'b1110;
        issue(4'd0, 5'd1, 5'd2, 5'd3, 64'd0);
        cyc();
        chk("add_keeps_flags", flags, 4'b0001);

        issue(4'd7, 5'd4, 5'd0, 5'd0, 64'h1008);
        chk("stur_addr_we", {WE, EN_ADDR, K}, {1'b0, 1'b1, 64'h1008});
        cyc();
        chk("stur_wr", {WE, EN_B, SB}, {1'b1, 1'b1, 5'd4});
        cyc();
        issue(4'd6, 5'd5, 5'd0, 5'd0, 64'h1008);
        chk("ldur_c1", {OE, W}, 2'b10);
        cyc();
        chk("ldur_c2", {OE, W, DA}, {2'b11, 5'd5});
        cyc();

        issue(4'hF, 5'd1, 5'd1, 5'd1, 64'd7);
        chk("illegal", {instr_err, W, WE}, 3'b100);
        cyc();

        issue(4'd7, 5'd4, 5'd0, 5'd0, 64'h1008);
        chk("stur_partial_we", WE, 0);
        rst = 0;
        cyc();
        chk("abort_we", WE, 0);
        chk("abort_ready", instr_ready, 0);
        rst = 1;
        cyc();
        chk("abort_ready_back", instr_ready, 1);

        for (int n = 0; n < 600; n++) begin
            instr_valid = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
            imm = {$urandom, $urandom};
            status = 4'($urandom);
            rst = ($urandom_range(0, 63) != 0);
            cyc();
        end
        rst = 1; instr_valid = 0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
